// File: rtl/pdm_dac.sv
// rtl/pdm_dac.sv - FIFO-fed first-order delta-sigma 1-bit PDM audio DAC
// Optional: define PDM_DAC_DITHER_EN to add 3-bit LFSR dither into the modulator sum.
module pdm_dac #(
    parameter int PERIOD = 1024,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [17:0]            in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   underrun_clr,
    output logic                   pdm_out,
    output logic                   sample_tick,
    output logic                   underrun,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = (PERIOD > 2) ? $clog2(PERIOD) : 1;

    logic [TW-1:0] r_tcnt;
    logic [17:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic [17:0]   r_cur;
    logic [17:0]   r_acc;
    logic          r_primed;
    logic          r_underrun;
    logic          r_sample_tick;
    logic          r_pdm;

    logic          w_tick;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [18:0]   w_sum;

    assign w_full  = (r_level == (AW+1)'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_tick  = (r_tcnt == TW'(PERIOD - 1));
    assign w_push  = in_valid && !w_full;
    // A push in a tick cycle is not visible to that tick: pop looks only at registered occupancy.
    assign w_pop   = w_tick && !w_empty;

`ifdef PDM_DAC_DITHER_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign w_sum = {1'b0, r_acc} + {1'b0, r_cur} + {16'b0, r_lfsr[2:0]};
`else
    assign w_sum = {1'b0, r_acc} + {1'b0, r_cur};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt        <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_level       <= '0;
            r_cur         <= 18'h20000;
            r_acc         <= '0;
            r_primed      <= 1'b0;
            r_underrun    <= 1'b0;
            r_sample_tick <= 1'b0;
            r_pdm         <= 1'b0;
        end else begin
            r_tcnt        <= w_tick ? '0 : r_tcnt + 1'b1;
            r_sample_tick <= w_tick;
            r_acc         <= w_sum[17:0];
            r_pdm         <= w_sum[18];

            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_cur    <= r_mem[r_rptr];
                r_rptr   <= r_rptr + 1'b1;
                r_primed <= 1'b1;
            end

            // Setting on an empty primed tick takes priority over a concurrent clear.
            if (w_tick && w_empty && r_primed) begin
                r_underrun <= 1'b1;
            end else if (underrun_clr) begin
                r_underrun <= 1'b0;
            end

            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (!w_push && w_pop) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wptr] <= in_data;
        end
    end

    assign in_ready    = !w_full;
    assign pdm_out     = r_pdm;
    assign sample_tick = r_sample_tick;
    assign underrun    = r_underrun;
    assign level       = r_level;

endmodule

// File: doc/pdm_dac.md
# pdm_dac

Audio output stage that consumes 18-bit unsigned mixed samples, such as the voice mixer output where silence is midscale 18'h20000. Samples enter through a valid/ready handshake into a small FIFO and are released at a fixed sample rate derived from `clk`. A first-order delta-sigma modulator turns each sample into a 1-bit pulse-density stream for an external RC filter. It sits at the end of the synth datapath, between the mixer tree and the audio pin.

## Interface
- `PERIOD`, 1024: clocks per output sample; ≥2.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `clk` input 1: single clock; everything is synchronous to its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_data` input 18: unsigned sample.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: FIFO can accept; equals !full.
- `underrun_clr` input 1: clears `underrun`.
- `pdm_out` output 1: registered pulse-density output.
- `sample_tick` output 1: one-cycle pulse when a sample slot starts.
- `underrun` output 1: sticky flag; a slot started with the FIFO empty after priming.
- `level` output $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Push: a push occurs when `in_valid && in_ready`. Data is written at the tail and `level` increments on the next edge.
- Tick counter: `tcnt` counts 0..PERIOD-1 and wraps. A tick occurs when `tcnt==PERIOD-1`, and `sample_tick` is registered high on the following cycle.
- On tick with FIFO not empty: pop the head into `cur` and set `primed`.
- On tick with FIFO empty: hold `cur`. If `primed`, set `underrun`.
- Push and pop in the same cycle: `level` is unchanged. A push is still refused when full, even if a pop happens that cycle.
- Push into an empty FIFO on a tick cycle: there is no bypass. The tick sees the FIFO empty, and the pushed sample waits for the next tick.
- `underrun_clr`: clears `underrun`. If a set and a clear happen in the same cycle, the set wins.
- Modulator update every clk: `sum[18:0] = {1'b0,acc} + {1'b0,cur}`, then `acc <= sum[17:0]` and `pdm_out <= sum[18]`.
- Output average: the mean density of `pdm_out` is cur/2^18.
- Reset values: `acc`=0, `cur`=18'h20000, `pdm_out`=0, `sample_tick`=0, `underrun`=0, `primed`=0, `level`=0, FIFO pointers 0, `tcnt`=0.
- `in_ready`: 1 from the first cycle with `rst` low.
- Reset mid-operation: the FIFO contents are discarded and take no further effect.

## Timing
- Push to slot: a sample pushed in cycle t is in the FIFO at t+1. It is loaded at the first tick at or after t+1 where it is the head.
- Slot to output: `pdm_out` reflects a new `cur` starting 2 cycles after the tick.
- `sample_tick`: asserted in the cycle `cur` holds the new value.
- Rate: one sample per `PERIOD` clocks exactly, with no drift. The first tick after reset is at cycle PERIOD-1.
- Flags: `in_ready` and `level` come from registered state and have no combinational path from `in_valid`.

## Configuration
- `PDM_DAC_DITHER_EN` defined:
  - A 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1, seed 16'hACE1, advances every clk.
  - `{16'b0,lfsr[2:0]}` is added into `sum`.
  - This breaks idle tones. The bias is at most 7/2^18.
  - The LFSR resets to the seed.
- `PDM_DAC_DITHER_EN` undefined: no LFSR, and the output is fully deterministic as specified above. All test plan values assume this case.

## Test plan
- Reset then idle, `PERIOD`=8:
  - `level`=0, `in_ready`=1, `pdm_out` reset value 0.
  - `pdm_out` then settles to 0,1,0,1…
  - `underrun` stays 0 for 100 clocks, because the block is not primed.
- Fill: push 5 samples back-to-back, `PERIOD`=1024 → 4 are accepted, `in_ready`=0 after the 4th, `level`=4. Then 4 ticks → 4 pops, in order.
- Quarter scale: push 18'h10000 → after load, exactly one `pdm_out`=1 in every 4 clocks. Push 18'h00000 → after load and 2 cycles, `pdm_out` stays constant 0.
- Full scale: push 18'h3FFFF → at least 1023 ones in the 1024 clocks after load.
- Underrun, `PERIOD`=8:
  - Push one sample and let two ticks pass → `underrun`=1 the cycle after the 2nd tick, and `cur` holds the sample.
  - `underrun_clr` clears it. A clear coinciding with the next empty tick leaves `underrun`=1.
- Reset mid-operation: push 3 samples, assert `rst` one cycle → `level`=0, `cur`=18'h20000, `primed`=0. No stale sample appears at the next tick.
